gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised general-purpose I/O bank replacing the fixed four-channel, 32-bit `gp_in0..3`/`gp_out0..3` wiring of the RISC-V system. It provides `NCH` channels of `DW`-bit registered outputs and synchronised inputs behind a simple CPU register port. It adds per-bit edge-detect interrupts with sticky status and a single combined IRQ line to the CPU.

## Interface
- `NCH`, 4: number of channels, 1..16.
- `DW`, 32: channel width in bits, 1..32.
- `EDGE`, 0: interrupt edge select. 0 = rising, 1 = falling, 2 = both.
- `AW`, `$clog2(NCH)+2`: register address width. Derived; do not override.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `cs`  in  1: register access strobe, one cycle per access.
- `we`  in  1: 1 = write, 0 = read; qualified by `cs`.
- `addr`  in  AW: `{channel, sel[1:0]}`.
- `wdata`  in  DW: write data.
- `rdata`  out  DW: registered read data.
- `gp_in`  in  NCH*DW: asynchronous inputs; channel n occupies bits `[n*DW +: DW]`.
- `gp_out`  out  NCH*DW: registered outputs, same packing as `gp_in`.
- `irq`  out  1: registered OR of all enabled, pending status bits.

## Operation
- Per channel, three flops in series: `s1 <= gp_in`, `s2 <= s1`, `s3 <= s2`.
- Edge vector per channel, selected by `EDGE`:
  - rising: `s2 & ~s3`
  - falling: `~s2 & s3`
  - both: `s2 ^ s3`
- Register map per channel, selected by `sel`:
  - 0 OUT (rw): drives `gp_out` for that channel.
  - 1 IN (ro): reads `s2`. Writes are ignored.
  - 2 IEN (rw): per-bit interrupt enable.
  - 3 ISTAT (r/w1c): sticky pending bits.
- ISTAT update every cycle: `stat <= (stat & ~clr) | (edge & ien)`.
  - `clr` = `wdata` on a write to ISTAT, else 0.
  - A new edge on the same bit in the same cycle as its clear wins: the bit stays 1.
- `irq <= |(all stat bits of all channels)`.
- Reads: `rdata` updates on the clock after `cs & ~we`. It holds its value until the next read; writes do not alter `rdata`.
- Channel index >= `NCH` (when `NCH` is not a power of two): reads return 0, writes are ignored.
- Reset clears `gp_out`, `rdata`, `irq`, all IEN, all ISTAT and all sync flops to 0.
  - Because IEN = 0 out of reset, inputs already high at reset release cannot latch status.
- Reset mid-operation: all state clears immediately and asynchronously. A pending read returns nothing; the first access after reset deassertion is serviced normally.
- Width: `wdata`/`rdata` are `DW` bits. No byte enables. No sign handling.

## Timing
- Write: the register updates at the clock edge where `cs & we` is sampled. For OUT, `gp_out` changes at that same edge (latency 1 from strobe).
- Read: `rdata` is valid on the cycle after the strobe (latency 1).
  - Back-to-back reads each return their own data one cycle later.
  - A read of OUT or IEN in the cycle immediately after a write to that register returns the new value.
- Input path, with `gp_in` changing before edge k:
  - `s1` at k
  - `s2` (IN visible to a read strobed in cycle k+1) at k+1
  - ISTAT set at k+2
  - `irq` high at k+3
- Clear path: a w1c write at edge k clears ISTAT at k; `irq` drops at k+1 if no other bits are pending.
- Input pulses shorter than one clock period may be missed. This is not guaranteed.

## Test plan
- Reset: hold `reset` for 10 cycles with `gp_in` all 1s -> `gp_out = 0`, `rdata = 0`, `irq = 0`; after release, read ISTAT of every channel -> 0.
- OUT/IN, `NCH=4`, `DW=32`:
  - write `32'hDEADBEEF` to ch2 OUT -> `gp_out[95:64] = DEADBEEF` at the write edge; read back the same value with latency 1.
  - drive `gp_in[31:0] = 32'h0000_0ABC` -> ch0 IN reads `ABC` two cycles after the change.
- Rising IRQ, `EDGE=0`: set ch1 IEN = `32'h1`; toggle `gp_in[32]` 0->1 -> ISTAT = 1 and `irq` = 1 three edges after the change; a 1->0 transition sets nothing.
- W1C race: with ch1 bit0 pending, write ISTAT = 1 in the same cycle a new rising edge reaches bit0 -> bit stays 1, `irq` stays 1. A later write of 1 with no edge -> ISTAT = 0, `irq` = 0 one cycle later.
- `EDGE=2`, `NCH=3`, `DW=8`:
  - both transitions of `gp_in[20]` each set ch2 bit4.
  - reads of address `{2'd3, 2'd0}` return 0; writes to that address change no `gp_out` bit.
- Async reset mid-operation: assert `reset` between clock edges while `irq = 1` and OUT is nonzero -> `irq`, `gp_out` and `rdata` go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: NCH channels of DW-bit registered outputs and synchronised inputs,
// with per-bit edge-detect interrupts, sticky w1c status and one combined IRQ.
module gpio_bank #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned EDGE = 0,
    parameter int unsigned AW   = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata,
    input  logic [NCH*DW-1:0] gp_in,
    output logic [NCH*DW-1:0] gp_out,
    output logic              irq
);

    localparam int unsigned BW = NCH * DW;

    localparam logic [1:0] SEL_OUT  = 2'd0;
    localparam logic [1:0] SEL_IN   = 2'd1;
    localparam logic [1:0] SEL_IEN  = 2'd2;
    localparam logic [1:0] SEL_STAT = 2'd3;

    logic [BW-1:0] s1_q;
    logic [BW-1:0] s2_q;
    logic [BW-1:0] s3_q;
    logic [BW-1:0] out_q;
    logic [BW-1:0] out_d;
    logic [BW-1:0] ien_q;
    logic [BW-1:0] ien_d;
    logic [BW-1:0] stat_q;
    logic [BW-1:0] stat_d;
    logic [BW-1:0] clr;
    logic [BW-1:0] edge_vec;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          irq_q;
    logic          irq_d;
    logic [1:0]    sel;
    logic [AW-1:0] ch_idx;

    assign sel    = addr[1:0];
    assign ch_idx = addr >> 2;

    // s3 is only the previous sample of s2; edges are judged on the settled pair
    generate
        if (EDGE == 0) begin : g_rise
            assign edge_vec = s2_q & ~s3_q;
        end else if (EDGE == 1) begin : g_fall
            assign edge_vec = ~s2_q & s3_q;
        end else begin : g_both
            assign edge_vec = s2_q ^ s3_q;
        end
    endgenerate

    // Register port decode; channel indices beyond NCH match no slot
    always_comb begin
        out_d   = out_q;
        ien_d   = ien_q;
        clr     = '0;
        rdata_d = rdata_q;
        if (cs && !we) begin
            rdata_d = '0;
        end
        for (int unsigned n = 0; n < NCH; n++) begin
            if (cs && (ch_idx == AW'(n))) begin
                if (we) begin
                    case (sel)
                        SEL_OUT:  out_d[n*DW +: DW] = wdata;
                        SEL_IEN:  ien_d[n*DW +: DW] = wdata;
                        SEL_STAT: clr[n*DW +: DW]   = wdata;
                        default:  ;
                    endcase
                end else begin
                    case (sel)
                        SEL_OUT: rdata_d = out_q[n*DW +: DW];
                        SEL_IN:  rdata_d = s2_q[n*DW +: DW];
                        SEL_IEN: rdata_d = ien_q[n*DW +: DW];
                        default: rdata_d = stat_q[n*DW +: DW];
                    endcase
                end
            end
        end
        // A fresh edge outranks a same-cycle clear of that bit
        stat_d = (stat_q & ~clr) | (edge_vec & ien_q);
        irq_d  = |stat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            out_q   <= '0;
            ien_q   <= '0;
            stat_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            s1_q    <= gp_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            out_q   <= out_d;
            ien_q   <= ien_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign gp_out = out_q;
    assign rdata  = rdata_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: random register/input traffic checked against a
// cycle-level reference model, plus directed edge, w1c, out-of-range and reset cases.
module tb_gpio_bank;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int BW    = NCH * DW;
    localparam int AW    = 4;
    localparam int NCH_B = 3;
    localparam int DW_B  = 8;
    localparam int AW_B  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cs;
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         wdata;
    logic [DW-1:0]         rdata;
    logic [BW-1:0]         gp_in;
    logic [BW-1:0]         gp_out;
    logic                  irq;
    logic                  cs_b;
    logic                  we_b;
    logic [AW_B-1:0]       addr_b;
    logic [DW_B-1:0]       wdata_b;
    logic [DW_B-1:0]       rdata_b;
    logic [NCH_B*DW_B-1:0] gp_in_b;
    logic [NCH_B*DW_B-1:0] gp_out_b;
    logic                  irq_b;

    gpio_bank #(.NCH(NCH), .DW(DW), .EDGE(0)) u_dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .gp_in(gp_in), .gp_out(gp_out), .irq(irq)
    );

    gpio_bank #(.NCH(NCH_B), .DW(DW_B), .EDGE(2)) u_dut_b (
        .clk(clk), .reset(reset), .cs(cs_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .gp_in(gp_in_b), .gp_out(gp_out_b), .irq(irq_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] gp_out;
        logic          irq;
        logic [DW-1:0] rdata;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference state: architectural registers plus the last three applied inputs
    logic [DW-1:0] m_out [NCH];
    logic [DW-1:0] m_ien [NCH];
    logic [DW-1:0] m_stat[NCH];
    logic [DW-1:0] m_rdata;
    logic          m_irq;
    logic [BW-1:0] hist[3];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Predict DUT outputs after the coming clock edge from the inputs now applied
    task automatic model_step();
        sb_t           e;
        logic [BW-1:0] rise;
        logic [DW-1:0] clr[NCH];
        int            ch;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_out[i]  = '0;
                m_ien[i]  = '0;
                m_stat[i] = '0;
            end
            m_rdata = '0;
            m_irq   = 1'b0;
            for (int i = 0; i < 3; i++) hist[i] = '0;
        end else begin
            rise  = hist[1] & ~hist[2];
            m_irq = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_irq  = m_irq | (m_stat[i] != '0);
                clr[i] = '0;
            end
            ch = int'(addr[3:2]);
            if (cs && !we) begin
                case (addr[1:0])
                    2'd0:    m_rdata = m_out[ch];
                    2'd1:    m_rdata = hist[1][ch*DW +: DW];
                    2'd2:    m_rdata = m_ien[ch];
                    default: m_rdata = m_stat[ch];
                endcase
            end
            if (cs && we && addr[1:0] == 2'd3) clr[ch] = wdata;
            for (int i = 0; i < NCH; i++)
                m_stat[i] = (m_stat[i] & ~clr[i]) | (rise[i*DW +: DW] & m_ien[i]);
            if (cs && we && addr[1:0] == 2'd0) m_out[ch] = wdata;
            if (cs && we && addr[1:0] == 2'd2) m_ien[ch] = wdata;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = gp_in;
        end
        for (int i = 0; i < NCH; i++) e.gp_out[i*DW +: DW] = m_out[i];
        e.irq   = m_irq;
        e.rdata = m_rdata;
        sb_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge
    always @(posedge clk) begin : mon
        sb_t e;
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underrun: no expectation queued (t=%0t)", $time);
        end else begin
            e = sb_q.pop_front();
            chk("gp_out", gp_out, e.gp_out);
            chk("irq", BW'(irq), BW'(e.irq));
            chk("rdata", BW'(rdata), BW'(e.rdata));
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic a_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic a_rd(input logic [AW-1:0] a);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        cs = 1'b0;
    endtask

    task automatic b_wr(input logic [AW_B-1:0] a, input logic [DW_B-1:0] d);
        cs_b = 1'b1; we_b = 1'b1; addr_b = a; wdata_b = d;
        tick();
        cs_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic b_rd(input logic [AW_B-1:0] a);
        cs_b = 1'b1; we_b = 1'b0; addr_b = a;
        tick();
        cs_b = 1'b0;
    endtask

    initial begin
        int idx;
        reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; gp_in = '1;
        cs_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; gp_in_b = '1;
        idle(10);
        chk("b_reset_gp_out", BW'(gp_out_b), '0);
        chk("b_reset_irq", BW'(irq_b), '0);
        chk("b_reset_rdata", BW'(rdata_b), '0);
        reset = 1'b0;

        for (int i = 0; i < NCH; i++) begin
            a_rd(AW'(i*4 + 3));
            chk("a_istat_after_reset", BW'(rdata), '0);
        end
        for (int i = 0; i < NCH_B; i++) begin
            b_rd(AW_B'(i*4 + 3));
            chk("b_istat_after_reset", BW'(rdata_b), '0);
        end
        gp_in = '0; gp_in_b = '0;
        idle(4);

        a_wr(4'b1000, 32'hDEADBEEF);
        chk("ch2_out_at_write_edge", BW'(gp_out[95:64]), BW'(32'hDEADBEEF));
        a_rd(4'b1000);
        chk("ch2_out_readback", BW'(rdata), BW'(32'hDEADBEEF));

        gp_in[31:0] = 32'h0000_0ABC;
        a_rd(4'b0001);
        a_rd(4'b0001);
        chk("ch0_in_too_early", BW'(rdata), '0);
        a_rd(4'b0001);
        chk("ch0_in_visible", BW'(rdata), BW'(32'hABC));

        // Channel B: both-edge interrupts on bit 4 of channel 2, out-of-range slot
        b_wr(4'b1010, 8'h10);
        b_wr(4'b0000, 8'hA5);
        b_wr(4'b0100, 8'h3C);
        b_wr(4'b1000, 8'h81);
        chk("b_gp_out_written", BW'(gp_out_b), BW'(24'h813CA5));
        b_wr(4'b1100, 8'hFF);
        chk("b_oor_write_ignored", BW'(gp_out_b), BW'(24'h813CA5));
        gp_in_b[20] = 1'b1;
        idle(3);
        chk("b_irq_not_before_k3", BW'(irq_b), '0);
        tick();
        chk("b_irq_rise_at_k3", BW'(irq_b), BW'(1'b1));
        b_rd(4'b1011);
        chk("b_istat_rise", BW'(rdata_b), BW'(8'h10));
        b_rd(4'b1100);
        chk("b_oor_read_zero", BW'(rdata_b), '0);
        b_wr(4'b1011, 8'h10);
        chk("b_irq_holds_at_clear_edge", BW'(irq_b), BW'(1'b1));
        tick();
        chk("b_irq_drops_after_clear", BW'(irq_b), '0);
        b_rd(4'b1011);
        chk("b_istat_cleared", BW'(rdata_b), '0);
        gp_in_b[20] = 1'b0;
        idle(4);
        chk("b_irq_fall", BW'(irq_b), BW'(1'b1));
        b_rd(4'b1011);
        chk("b_istat_fall", BW'(rdata_b), BW'(8'h10));
        b_wr(4'b0000, 8'h00);
        chk("b_write_keeps_rdata", BW'(rdata_b), BW'(8'h10));
        chk("b_gp_out_ch0_cleared", BW'(gp_out_b), BW'(24'h813C00));

        // Rising interrupt on ch1 bit0
        a_wr(4'b0110, 32'h1);
        gp_in[32] = 1'b1;
        idle(3);
        chk("a_irq_not_before_k3", BW'(irq), '0);
        tick();
        chk("a_irq_at_k3", BW'(irq), BW'(1'b1));
        a_rd(4'b0111);
        chk("a_istat_rise", BW'(rdata), BW'(32'h1));
        a_wr(4'b0111, 32'h1);
        idle(2);
        gp_in[32] = 1'b0;
        idle(5);
        a_rd(4'b0111);
        chk("a_fall_sets_nothing", BW'(rdata), '0);
        chk("a_irq_low_after_fall", BW'(irq), '0);

        // Clear lands on the same edge as a new rising edge of the same bit
        gp_in[32] = 1'b1;
        idle(5);
        chk("race_pending_irq", BW'(irq), BW'(1'b1));
        gp_in[32] = 1'b0;
        idle(4);
        gp_in[32] = 1'b1;
        tick();
        tick();
        a_wr(4'b0111, 32'h1);
        tick();
        chk("race_irq_stays", BW'(irq), BW'(1'b1));
        a_rd(4'b0111);
        chk("race_bit_stays", BW'(rdata), BW'(32'h1));
        a_wr(4'b0111, 32'h1);
        chk("clear_irq_same_edge", BW'(irq), BW'(1'b1));
        tick();
        chk("clear_irq_next_edge", BW'(irq), '0);
        a_rd(4'b0111);
        chk("clear_istat", BW'(rdata), '0);

        repeat (1500) begin
            cs    = ($urandom_range(0, 9) < 6);
            we    = 1'($urandom_range(0, 1));
            addr  = AW'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, BW - 1));
                gp_in[idx] = ~gp_in[idx];
            end
            if ($urandom_range(0, 99) == 0) gp_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        cs = 1'b0; we = 1'b0;

        // Asynchronous reset between clock edges with live state
        a_wr(4'b0000, 32'h1234_5678);
        a_wr(4'b0110, 32'h1);
        gp_in = '0;
        a_wr(4'b0111, 32'hFFFF_FFFF);
        idle(4);
        gp_in[32] = 1'b1;
        idle(5);
        a_rd(4'b0000);
        chk("pre_reset_rdata", BW'(rdata), BW'(32'h1234_5678));
        chk("pre_reset_irq", BW'(irq), BW'(1'b1));
        model_step();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_gp_out", gp_out, '0);
        chk("async_irq", BW'(irq), '0);
        chk("async_rdata", BW'(rdata), '0);
        chk("async_b_gp_out", BW'(gp_out_b), '0);
        chk("async_b_irq", BW'(irq_b), '0);
        @(negedge clk);
        idle(2);
        reset = 1'b0;
        a_rd(4'b0000);
        chk("post_reset_out_read", BW'(rdata), '0);
        a_wr(4'b0000, 32'hCAFE_0001);
        chk("post_reset_gp_out", BW'(gp_out[31:0]), BW'(32'hCAFE_0001));
        a_rd(4'b0000);
        chk("post_reset_readback", BW'(rdata), BW'(32'hCAFE_0001));
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
